// File: rtl/phaseerr_table_arbiter.sv
// Round-robin arbiter that shares one phase-error lookup table among NREQ channels,
// tagging each lookup with its channel id and returning the table result to that channel.
module phaseerr_table_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TAB_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NREQ-1:0]   i_chan_enable,
    input  logic [NREQ-1:0]   i_req_valid,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic [9*NREQ-1:0] i_req_angles,
    input  logic [9*NREQ-1:0] i_req_phase,
    output logic [8:0]        o_tab_angles,
    output logic [8:0]        o_tab_phase,
    output logic              o_tab_strobe,
    input  logic [8:0]        i_tab_phi_error,
    input  logic [9:0]        i_tab_val_engle,
    output logic [NREQ-1:0]   o_rsp_valid,
    output logic [IDW-1:0]    o_rsp_id,
    output logic [8:0]        o_rsp_phi_error,
    output logic [9:0]        o_rsp_val_engle,
    output logic              o_busy
);

    localparam int DEPTH = TAB_LAT + 1;

    logic [IDW-1:0]  r_ptr;
    logic [DEPTH-1:0] r_tag_vld;
    logic [IDW-1:0]  r_tag_id [DEPTH];

    logic [NREQ-1:0] w_elig;
    logic            w_grant_vld;
    logic [IDW-1:0]  w_grant_id;
    logic [8:0]      w_sel_angle;
    logic [8:0]      w_sel_phase;
    logic            w_exit_vld;
    logic [IDW-1:0]  w_exit_id;

    assign w_elig     = i_req_valid & i_chan_enable;
    assign w_exit_vld = r_tag_vld[DEPTH-1];
    assign w_exit_id  = r_tag_id[DEPTH-1];

    // Search from the farthest candidate to the nearest so the channel closest after ptr wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(r_ptr) + k) % NREQ;
            if (w_elig[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        w_sel_angle = '0;
        w_sel_phase = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_vld && (w_grant_id == IDW'(i))) begin
                o_req_ready[i] = 1'b1;
                w_sel_angle    = i_req_angles[9*i +: 9];
                w_sel_phase    = i_req_phase[9*i +: 9];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ptr           <= IDW'(NREQ - 1);
            r_tag_vld       <= '0;
            for (int i = 0; i < DEPTH; i++) r_tag_id[i] <= '0;
            o_tab_angles    <= '0;
            o_tab_phase     <= '0;
            o_tab_strobe    <= 1'b0;
            o_rsp_valid     <= '0;
            o_rsp_id        <= '0;
            o_rsp_phi_error <= '0;
            o_rsp_val_engle <= '0;
            o_busy          <= 1'b0;
        end else begin
            o_tab_strobe <= w_grant_vld;
            if (w_grant_vld) begin
                r_ptr        <= w_grant_id;
                o_tab_angles <= w_sel_angle;
                o_tab_phase  <= w_sel_phase;
            end

            r_tag_vld   <= {r_tag_vld[DEPTH-2:0], w_grant_vld};
            r_tag_id[0] <= w_grant_id;
            for (int i = 1; i < DEPTH; i++) r_tag_id[i] <= r_tag_id[i-1];

            for (int i = 0; i < NREQ; i++)
                o_rsp_valid[i] <= w_exit_vld && (w_exit_id == IDW'(i));
            if (w_exit_vld) begin
                o_rsp_id        <= w_exit_id;
                o_rsp_phi_error <= i_tab_phi_error;
                o_rsp_val_engle <= i_tab_val_engle;
            end

            // Busy covers the response cycle too, so it drops the cycle after the last rsp_valid.
            o_busy <= w_grant_vld | (|r_tag_vld);
        end
    end

endmodule

// File: tb/tb_phaseerr_table_arbiter.sv
// Directed bench for phaseerr_table_arbiter: a TAB_LAT=1 instance and a TAB_LAT=3 instance,
// each fed by a behavioural table (phi = angle ^ phase, val = {1'b1, angle}).
module tb_phaseerr_table_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [3:0]  a_en, a_valid, a_ready, a_rsp_valid;
    logic [35:0] a_angles, a_phase;
    logic [8:0]  a_tab_angles, a_tab_phase, a_tab_phi, a_rsp_phi;
    logic [9:0]  a_tab_val, a_rsp_val;
    logic        a_tab_strobe, a_busy;
    logic [1:0]  a_rsp_id;

    logic [3:0]  b_en, b_valid, b_ready, b_rsp_valid;
    logic [35:0] b_angles, b_phase;
    logic [8:0]  b_tab_angles, b_tab_phase, b_rsp_phi;
    logic [9:0]  b_rsp_val;
    logic        b_tab_strobe, b_busy;
    logic [1:0]  b_rsp_id;
    logic [8:0]  b_pipe_phi [3];
    logic [9:0]  b_pipe_val [3];

    phaseerr_table_arbiter #(.NREQ(4), .IDW(2), .TAB_LAT(1)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_chan_enable(a_en), .i_req_valid(a_valid),
        .o_req_ready(a_ready), .i_req_angles(a_angles), .i_req_phase(a_phase),
        .o_tab_angles(a_tab_angles), .o_tab_phase(a_tab_phase), .o_tab_strobe(a_tab_strobe),
        .i_tab_phi_error(a_tab_phi), .i_tab_val_engle(a_tab_val),
        .o_rsp_valid(a_rsp_valid), .o_rsp_id(a_rsp_id), .o_rsp_phi_error(a_rsp_phi),
        .o_rsp_val_engle(a_rsp_val), .o_busy(a_busy)
    );

    phaseerr_table_arbiter #(.NREQ(4), .IDW(2), .TAB_LAT(3)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_chan_enable(b_en), .i_req_valid(b_valid),
        .o_req_ready(b_ready), .i_req_angles(b_angles), .i_req_phase(b_phase),
        .o_tab_angles(b_tab_angles), .o_tab_phase(b_tab_phase), .o_tab_strobe(b_tab_strobe),
        .i_tab_phi_error(b_pipe_phi[2]), .i_tab_val_engle(b_pipe_val[2]),
        .o_rsp_valid(b_rsp_valid), .o_rsp_id(b_rsp_id), .o_rsp_phi_error(b_rsp_phi),
        .o_rsp_val_engle(b_rsp_val), .o_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lookup tables with 1 and 3 cycles of latency.
    always @(posedge clk) begin
        a_tab_phi     <= a_tab_angles ^ a_tab_phase;
        a_tab_val     <= {1'b1, a_tab_angles};
        b_pipe_phi[0] <= b_tab_angles ^ b_tab_phase;
        b_pipe_val[0] <= {1'b1, b_tab_angles};
        b_pipe_phi[1] <= b_pipe_phi[0];
        b_pipe_val[1] <= b_pipe_val[0];
        b_pipe_phi[2] <= b_pipe_phi[1];
        b_pipe_val[2] <= b_pipe_val[1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = '0; b_valid = '0;
        a_en = '1; b_en = '1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        a_valid = '0; b_valid = '0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (a_tab_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b exp 0", a_tab_strobe); end
        checks++; if (a_rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", a_rsp_valid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", a_busy); end
        checks++; if (a_tab_angles !== 9'h0 || a_tab_phase !== 9'h0) begin errors++; $display("FAIL reset_tab: got %h/%h exp 000/000", a_tab_angles, a_tab_phase); end
        checks++; if (a_rsp_id !== 2'd0 || a_rsp_phi !== 9'h0 || a_rsp_val !== 10'h0) begin errors++; $display("FAIL reset_rsp_data: got %h/%h/%h exp 0/0/0", a_rsp_id, a_rsp_phi, a_rsp_val); end
        checks++; if (a_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0000", a_ready); end
    endtask

    task automatic test_single();
        a_angles = '0; a_phase = '0;
        a_angles[18 +: 9] = 9'h05A;
        a_phase[18 +: 9]  = 9'h101;
        a_valid = 4'b0100;
        settle();
        checks++; if (a_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b exp 0100", a_ready); end
        tick(); a_valid = '0; settle();
        checks++; if (a_tab_angles !== 9'h05A || a_tab_phase !== 9'h101 || a_tab_strobe !== 1'b1)
            begin errors++; $display("FAIL single_tab: got %h/%h/%b exp 05a/101/1", a_tab_angles, a_tab_phase, a_tab_strobe); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy1: got %b exp 1", a_busy); end
        tick(); settle();
        checks++; if (a_tab_strobe !== 1'b0 || a_rsp_valid !== 4'b0) begin errors++; $display("FAIL single_gap: got strobe %b rsp %b exp 0/0000", a_tab_strobe, a_rsp_valid); end
        tick(); settle();
        checks++; if (a_rsp_valid !== 4'b0100 || a_rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp: got %b id %0d exp 0100 id 2", a_rsp_valid, a_rsp_id); end
        checks++; if (a_rsp_phi !== 9'h15B || a_rsp_val !== 10'h25A) begin errors++; $display("FAIL single_rsp_data: got %h/%h exp 15b/25a", a_rsp_phi, a_rsp_val); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy_rsp: got %b exp 1", a_busy); end
        tick(); settle();
        checks++; if (a_rsp_valid !== 4'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got rsp %b busy %b exp 0000/0", a_rsp_valid, a_busy); end
        checks++; if (a_rsp_phi !== 9'h15B || a_rsp_id !== 2'd2) begin errors++; $display("FAIL single_hold: got %h id %0d exp 15b id 2", a_rsp_phi, a_rsp_id); end
        drain();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_angles[9*i +: 9] = 9'(9'h010 + i);
            a_phase[9*i +: 9]  = 9'(9'h020 + i);
        end
        for (int k = 0; k < 15; k++) begin
            a_valid = (k < 12) ? 4'b1111 : 4'b0000;
            settle();
            if (k < 12) begin
                checks++; if (a_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, a_ready, 4'(1 << (k % 4))); end
            end
            if (k >= 3) begin
                checks++; if (a_rsp_valid !== 4'(1 << ((k-3) % 4)) || a_rsp_id !== 2'((k-3) % 4))
                    begin errors++; $display("FAIL rr_rsp[%0d]: got %b id %0d exp %b id %0d", k, a_rsp_valid, a_rsp_id, 4'(1 << ((k-3) % 4)), (k-3) % 4); end
                checks++; if (a_rsp_val !== 10'(10'h210 + ((k-3) % 4))) begin errors++; $display("FAIL rr_data[%0d]: got %h exp %h", k, a_rsp_val, 10'(10'h210 + ((k-3) % 4))); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_disabled();
        a_en = 4'b0111;
        a_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            settle();
            checks++; if (a_ready !== 4'b0010) begin errors++; $display("FAIL dis_ready[%0d]: got %b exp 0010", k, a_ready); end
            if (k >= 3) begin
                checks++; if (a_rsp_valid !== 4'b0010) begin errors++; $display("FAIL dis_rsp[%0d]: got %b exp 0010", k, a_rsp_valid); end
            end
            tick();
        end
        drain();
        a_en = '1;
    endtask

    task automatic test_enable_drop();
        a_angles[0 +: 9] = 9'h0C3;
        a_phase[0 +: 9]  = 9'h03C;
        a_valid = 4'b0001;
        settle();
        checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL drop_first: got %b exp 0001", a_ready); end
        tick(); a_en = 4'b1110; settle();
        for (int k = 1; k < 5; k++) begin
            checks++; if (a_ready !== 4'b0000) begin errors++; $display("FAIL drop_ready[%0d]: got %b exp 0000", k, a_ready); end
            if (k == 3) begin
                checks++; if (a_rsp_valid !== 4'b0001 || a_rsp_id !== 2'd0 || a_rsp_val !== 10'h2C3 || a_rsp_phi !== 9'h0FF)
                    begin errors++; $display("FAIL drop_rsp: got %b id %0d %h/%h exp 0001 id 0 0ff/2c3", a_rsp_valid, a_rsp_id, a_rsp_phi, a_rsp_val); end
            end else begin
                checks++; if (a_rsp_valid !== 4'b0000) begin errors++; $display("FAIL drop_norsp[%0d]: got %b exp 0000", k, a_rsp_valid); end
            end
            tick(); settle();
        end
        drain();
        a_en = '1;
    endtask

    task automatic test_reset_inflight();
        a_valid = 4'b1000;
        tick();
        a_valid = 4'b0010;
        tick();
        a_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++; if (a_rsp_valid !== 4'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL rstfl[%0d]: got rsp %b busy %b exp 0000/0", k, a_rsp_valid, a_busy); end
            tick();
        end
        a_valid = 4'b1111;
        settle();
        checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL rstfl_first_grant: got %b exp 0001", a_ready); end
        tick();
        drain();
    endtask

    task automatic test_back_to_back();
        b_angles = '0; b_phase = '0;
        b_phase[0 +: 9] = 9'h100;
        b_valid = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            b_angles[0 +: 9] = 9'(k + 1);
            b_valid = (k < 3) ? 4'b0001 : 4'b0000;
            settle();
            if (k < 3) begin
                checks++; if (b_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp 0001", k, b_ready); end
            end
            if (k >= 5 && k <= 7) begin
                checks++; if (b_rsp_valid !== 4'b0001 || b_rsp_id !== 2'd0) begin errors++; $display("FAIL b2b_rsp[%0d]: got %b id %0d exp 0001 id 0", k, b_rsp_valid, b_rsp_id); end
                checks++; if (b_rsp_val !== 10'(10'h200 + k - 4) || b_rsp_phi !== 9'(9'h100 + k - 4))
                    begin errors++; $display("FAIL b2b_data[%0d]: got %h/%h exp %h/%h", k, b_rsp_phi, b_rsp_val, 9'(9'h100 + k - 4), 10'(10'h200 + k - 4)); end
            end else if (k >= 3) begin
                checks++; if (b_rsp_valid !== 4'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got %b exp 0000", k, b_rsp_valid); end
            end
            tick();
        end
        settle();
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b exp 0", b_busy); end
        drain();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1;
        a_en = '1; a_valid = '0; a_angles = '0; a_phase = '0;
        b_en = '1; b_valid = '0; b_angles = '0; b_phase = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_disabled();
        test_enable_drop();
        test_reset_inflight();
        do_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/phaseerr_table_arbiter.md
Name: phaseerr_table_arbiter

Overview:
- Shares one phase-error lookup table among NREQ demodulator channels.
- Table inputs: 9-bit angle and 9-bit phase-accumulator value. Table outputs: 9-bit phi_error and 10-bit val_engle, TAB_LAT cycles after its clock edge.
- Arbitrates channel requests round-robin, issues at most one lookup per cycle, tags requests through a pipeline, and routes each result back to its requesting channel.

Parameters:
- NREQ, 4: number of requesting channels (2..8).
- IDW, 2: channel-id width; must satisfy 2^IDW >= NREQ.
- TAB_LAT, 1: table latency in cycles, from the edge that samples tab_* to the cycle its result is stable (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- chan_enable  in  NREQ  per-channel arbitration enable.
- req_valid  in  NREQ  per-channel request valid.
- req_ready  out  NREQ  per-channel accept; at most one bit high.
- req_angles  in  9*NREQ  channel i angle in bits [9i+8:9i].
- req_phase  in  9*NREQ  channel i phase_acum_mod in bits [9i+8:9i].
- tab_angles  out  9  table angle input, registered.
- tab_phase  out  9  table phase input, registered.
- tab_strobe  out  1  high when tab_* carry a real lookup.
- tab_phi_error  in  9  table result.
- tab_val_engle  in  10  table result.
- rsp_valid  out  NREQ  one-hot response strobe, one cycle.
- rsp_id  out  IDW  index of the responding channel.
- rsp_phi_error  out  9  registered result.
- rsp_val_engle  out  10  registered result.
- busy  out  1  high while any lookup is in flight.

Behaviour:
- Reset: when reset_n=0 at a rising edge, all registered outputs clear to 0 (tab_*, rsp_*, busy), the tag pipeline clears, and the RR pointer is set to NREQ-1, so channel 0 has first priority.
- Reset mid-operation: in-flight lookups are discarded and produce no rsp_valid.
- Eligibility: channel i is eligible when req_valid[i] & chan_enable[i].
- Grant (combinational, cycle t): the first eligible channel searching ptr+1, ptr+2, … modulo NREQ.
- req_ready is one-hot for the granted channel and all-zero when no channel is eligible. A handshake is valid & ready in the same cycle.
- On a handshake in cycle t:
  - At the end of t: tab_angles/tab_phase load the granted channel's slices, tab_strobe=1, ptr=granted index.
  - With no grant, tab_strobe=0 and tab_angles/tab_phase hold their previous values.
- Tag pipeline: a shift register of depth TAB_LAT+1 carrying {valid, id}, advanced every cycle.
- Response: the tag leaves the pipeline in cycle t+1+TAB_LAT. At the end of that cycle tab_phi_error/tab_val_engle are registered into rsp_*, rsp_id takes the tag id, and rsp_valid becomes one-hot.
- Total latency, handshake to rsp_valid: TAB_LAT+2 cycles (3 at default).
- rsp_valid is 0 in every cycle without an exiting valid tag. rsp_* data holds its previous value when rsp_valid=0.
- Throughput: one lookup per cycle, sustained. There is no response backpressure; channels must accept rsp in the cycle it is asserted.
- Fairness: with all NREQ channels continuously eligible, grants rotate 0,1,…,NREQ-1,0,… Any eligible channel is granted within NREQ cycles.
- Single eligible channel: it is granted every cycle regardless of ptr.
- chan_enable deasserted with a lookup in flight: the in-flight response is still delivered. Only future grants are blocked.
- Channel with req_valid held high and chan_enable low: never granted, req_ready stays 0.
- busy = OR of the tag-pipeline valid bits, plus tab_strobe. It deasserts in the cycle after the last rsp_valid pulse.
- Widths: data passes through unmodified, with no arithmetic on the data path. The ptr increment wraps modulo NREQ, including non-power-of-two NREQ.

Test Plan:
- Reset, then a single request on ch2 with angle 0x05A, phase 0x101 at cycle 5 → req_ready[2]=1 in cycle 5; tab_angles=0x05A, tab_phase=0x101, tab_strobe=1 in cycle 6; rsp_valid=4'b0100, rsp_id=2 in cycle 8 with the table's result for that input.
- All 4 channels valid and enabled for 12 cycles → grant order 0,1,2,3,0,1,2,3,0,1,2,3; rsp_id sequence identical, delayed 3 cycles; no bubbles.
- Ch1 and ch3 valid, chan_enable=4'b0111 → only ch1 is granted, every cycle; req_ready[3]=0 throughout.
- Issue to ch0, then drop chan_enable[0] in the next cycle → ch0 response still arrives 3 cycles after its handshake; no further ch0 grants.
- Two lookups in flight, then reset_n=0 for 1 cycle → rsp_valid stays 0 for the following 4 cycles, busy=0, and the first grant after reset goes to ch0.
- TAB_LAT=3, back-to-back requests on ch0 (angles 0x001, 0x002, 0x003) → responses arrive in order 5, 6 and 7 cycles after the first handshake, each with rsp_id=0.
